// File: rtl/spi_cv_frame_rx.sv
// SPI mode-0 slave that receives a frame of CV words, oversampled and deglitched in the i_Clock domain.
// Optional checksum word enabled by defining SPI_CV_CHECKSUM_EN.
module spi_cv_frame_rx #(
   parameter int unsigned CHANNELS     = 6,
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned STABLE_COUNT = 3
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_SPI_CS,
   input  logic                      i_SPI_Clock,
   input  logic                      i_SPI_Data,
   output logic [CHANNELS*WIDTH-1:0] o_Data,
   output logic                      o_Data_Valid,
   output logic                      o_Frame_Error,
   output logic                      o_Busy
);

`ifdef SPI_CV_CHECKSUM_EN
   localparam int unsigned FRAME_WORDS = CHANNELS + 1;
`else
   localparam int unsigned FRAME_WORDS = CHANNELS;
`endif
   localparam int unsigned WORD_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int unsigned BIT_W    = $clog2(WIDTH);
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned DATA_W   = CHANNELS * WIDTH;
   localparam int unsigned L_CS     = 0;
   localparam int unsigned L_SCLK   = 1;
   localparam int unsigned L_MOSI   = 2;
   localparam logic [2:0]  LINE_RST = 3'b001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      DONE    = 2'd2
   } state_t;

   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       filt_q;
   logic [CNT_W-1:0] stab_cnt_q [3];
   logic             cs_prev_q;
   logic             sclk_prev_q;
   logic [1:0]       sync_vld_q;
   logic             armed_q;
   logic             sclk_rise_q;
   logic             cs_fall_q;
   logic             cs_rise_q;

   // Synchronise, deglitch and edge-detect the three SPI lines.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync1_q     <= LINE_RST;
         sync2_q     <= LINE_RST;
         filt_q      <= LINE_RST;
         for (int i = 0; i < 3; i++) stab_cnt_q[i] <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         sync_vld_q  <= '0;
         armed_q     <= 1'b0;
         sclk_rise_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
      end else begin
         sync1_q <= {i_SPI_Data, i_SPI_Clock, i_SPI_CS};
         sync2_q <= sync1_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               stab_cnt_q[i] <= '0;
            end else if (stab_cnt_q[i] == CNT_W'(STABLE_COUNT - 1)) begin
               filt_q[i]     <= sync2_q[i];
               stab_cnt_q[i] <= '0;
            end else begin
               stab_cnt_q[i] <= stab_cnt_q[i] + CNT_W'(1);
            end
         end
         cs_prev_q   <= filt_q[L_CS];
         sclk_prev_q <= filt_q[L_SCLK];
         sync_vld_q  <= {sync_vld_q[0], 1'b1};
         // A CS held low across reset must go high before a frame may start.
         armed_q     <= armed_q | (sync_vld_q[1] & sync2_q[L_CS] & filt_q[L_CS]);
         sclk_rise_q <= filt_q[L_SCLK] & ~sclk_prev_q;
         cs_fall_q   <= ~filt_q[L_CS] & cs_prev_q;
         cs_rise_q   <= filt_q[L_CS] & ~cs_prev_q;
      end
   end

   state_t            state_q,    state_d;
   logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
   logic [WIDTH-1:0]  shift_q,    shift_d;
   logic [DATA_W-1:0] staging_q,  staging_d;
   logic [DATA_W-1:0] data_q,     data_d;
   logic              valid_q,    valid_d;
   logic              err_q,      err_d;
   logic              busy_q,     busy_d;
   logic [WIDTH-1:0]  shift_next;
   logic              word_done;
   logic              last_word;
`ifdef SPI_CV_CHECKSUM_EN
   logic [WIDTH-1:0]  sum_q,      sum_d;
`endif

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         shift_q    <= '0;
         staging_q  <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SPI_CV_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         shift_q    <= shift_d;
         staging_q  <= staging_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
`ifdef SPI_CV_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   // Frame FSM: CS rise has priority over a coincident SCLK rise.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      shift_d    = shift_q;
      staging_d  = staging_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
`ifdef SPI_CV_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      shift_next = {shift_q[WIDTH-2:0], filt_q[L_MOSI]};
      word_done  = (bit_cnt_q == BIT_W'(WIDTH - 1));
      last_word  = (word_cnt_q == WORD_W'(FRAME_WORDS - 1));

      case (state_q)
         IDLE: begin
            if (cs_fall_q && armed_q) begin
               state_d    = RECEIVE;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               shift_d    = '0;
`ifdef SPI_CV_CHECKSUM_EN
               sum_d      = '0;
`endif
            end
         end
         RECEIVE: begin
            if (cs_rise_q) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (sclk_rise_q) begin
               shift_d = shift_next;
               if (word_done) begin
                  bit_cnt_d  = '0;
                  word_cnt_d = word_cnt_q + WORD_W'(1);
                  for (int i = 0; i < int'(CHANNELS); i++) begin
                     if (word_cnt_q == WORD_W'(i)) staging_d[i*WIDTH +: WIDTH] = shift_next;
                  end
`ifdef SPI_CV_CHECKSUM_EN
                  if (!last_word) sum_d = sum_q + shift_next;
                  if (last_word) begin
                     state_d = DONE;
                     if (shift_next == sum_q) begin
                        data_d  = staging_d;
                        valid_d = 1'b1;
                     end else begin
                        err_d   = 1'b1;
                     end
                  end
`else
                  if (last_word) begin
                     state_d = DONE;
                     data_d  = staging_d;
                     valid_d = 1'b1;
                  end
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         DONE: begin
            if (cs_rise_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RECEIVE);
   end

   assign o_Data        = data_q;
   assign o_Data_Valid  = valid_q;
   assign o_Frame_Error = err_q;
   assign o_Busy        = busy_q;

endmodule

// File: doc/spi_cv_frame_rx.md
# spi_cv_frame_rx

Parametrised, fully synchronous SPI slave receiving a frame of CV words from the microcontroller ADC. It runs entirely in the `i_Clock` domain, oversampling and deglitching SCLK/MOSI/CS. It replaces the fixed 6×16-bit receiver with configurable channel count, word width and filter depth, atomic double-buffered outputs, frame-error reporting and an optional checksum word. It sits between the MCU SPI pins and the oscillator/parameter logic.

## Interface
- `CHANNELS`, 6: number of data words per frame (1–16).
- `WIDTH`, 16: bits per word (8–32).
- `STABLE_COUNT`, 3: consecutive clocks a synchronised line must hold a new value before its filtered copy updates (1–15).
- `i_Clock`  in  1  system clock.
- `i_Reset`  in  1  reset, synchronous, active-high; clock `i_Clock`.
- `i_SPI_CS`  in  1  chip select, active-low, asynchronous.
- `i_SPI_Clock`  in  1  SPI clock, mode 0 (idle low, sample on rising edge), asynchronous.
- `i_SPI_Data`  in  1  MOSI, MSB first, asynchronous.
- `o_Data`  out  CHANNELS*WIDTH  output register bank; channel n occupies `[n*WIDTH +: WIDTH]`; channel 0 is the first word sent.
- `o_Data_Valid`  out  1  one-cycle pulse when `o_Data` has been updated with a complete frame.
- `o_Frame_Error`  out  1  one-cycle pulse when a frame is aborted or fails its check.
- `o_Busy`  out  1  high while a frame is being received (state RECEIVE).

## Operation
- Input conditioning: each pin passes through a 2-flop synchroniser, then a per-line filter. The filtered value takes the synchronised value only after that value has differed from the filtered value for `STABLE_COUNT` consecutive clocks. Any return to the filtered value clears that line's counter. The three lines filter independently.
- Edge detect on the filtered lines: `sclk_rise`, `cs_fall`, `cs_rise`; each is a one-cycle strobe.
- States: IDLE, RECEIVE, DONE.
  - IDLE: on `cs_fall`, clear the bit and word counters and the shift register, then go to RECEIVE.
  - RECEIVE: on each `sclk_rise`, shift filtered MOSI into the LSB.
    - When the bit counter reaches WIDTH-1, write the completed word to `staging[word]`, clear the bit counter and increment the word counter.
    - On completing the last word of the frame, copy staging to `o_Data`, pulse `o_Data_Valid` and go to DONE.
  - DONE: ignore all `sclk_rise`; on `cs_rise`, go to IDLE.
- `cs_rise` in RECEIVE (short frame): pulse `o_Frame_Error`, leave `o_Data` unchanged, go to IDLE. Partial words are discarded.
- `cs_rise` and `sclk_rise` in the same cycle: CS wins. The edge is discarded, and a frame that edge would have completed is treated as an error.
- `sclk_rise` while filtered CS is high: ignored.
- `o_Data` only ever changes as a whole frame; a consumer never sees mixed frames.
- Reset values:
  - state IDLE; all counters 0.
  - filtered CS = 1; filtered SCLK = 0; filtered MOSI = 0.
  - `o_Data` = 0, staging = 0.
  - `o_Data_Valid` = 0, `o_Frame_Error` = 0, `o_Busy` = 0.
- Reset asserted mid-frame: the frame is lost, with no error pulse. After release, the block stays in IDLE until a fresh `cs_fall`; a CS already low at release does not start a frame.

## Timing
- Pin-to-filtered latency: 2 synchroniser clocks + `STABLE_COUNT` clocks.
- SPI requirement: SCLK high and low phases must each be at least `STABLE_COUNT`+3 clocks; MOSI must be stable for `STABLE_COUNT`+3 clocks around the rising edge.
- `o_Data` and `o_Data_Valid` update on the clock edge following the `sclk_rise` strobe of the frame's final bit. Total latency from the final pin edge is `STABLE_COUNT`+4 clocks.
- `o_Frame_Error` is asserted on the clock after the `cs_rise` strobe (or after the check for a checksum failure).
- `o_Busy` is high from the clock after `cs_fall` until the clock after completion or abort.
- Back-to-back frames are allowed once CS has been filtered high for at least 1 clock.

## Configuration
- `SPI_CV_CHECKSUM_EN` defined:
  - The frame is CHANNELS+1 words. The extra final word equals the sum of all channel words modulo 2^WIDTH.
  - On match: update `o_Data` and pulse `o_Data_Valid`.
  - On mismatch: pulse `o_Frame_Error` (same cycle as a valid pulse would be), leave `o_Data` unchanged, go to DONE.
- `SPI_CV_CHECKSUM_EN` undefined: the frame is exactly CHANNELS words, with no integrity check and no checksum adder or storage.

## Test plan
- Reset, then a default-parameter frame of words 0x0001…0x0006 with SCLK half-period 8 clocks -> one `o_Data_Valid` pulse; `o_Data[15:0]`=0x0001, `o_Data[95:80]`=0x0006; `o_Busy` low afterwards.
- CS raised after 3 words of a frame of 0xAAAA words -> `o_Frame_Error` pulses once, no `o_Data_Valid`, `o_Data` keeps previous frame values.
- 2-clock glitches injected on SCLK and CS (with `STABLE_COUNT`=3) during a valid frame of 0x1234 words -> frame received correctly, no error.
- 10 extra SCLK pulses after a complete frame, before CS rises -> ignored, exactly one `o_Data_Valid`, data unchanged by the extra bits.
- With `SPI_CV_CHECKSUM_EN`: frame 0xFFFF ×6 with checksum 0xFFFA -> valid. The same frame with checksum 0xFFFB -> `o_Frame_Error` and `o_Data` unchanged.
- `CHANNELS`=2, `WIDTH`=12; reset asserted mid-word, then a new frame of 0xABC, 0x123 -> no error pulse from the aborted frame; `o_Data`=24'h123ABC.
